// File: rtl/angle_sweep_ctrl_if.sv
// Result handshake bundle between the angle sweep controller and its consumer.
// The controller drives valid/data; the consumer drives ready.
interface angle_sweep_ctrl_if;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_cos;
    logic [7:0]  res_index;

    modport master (
        output res_valid,
        output res_cos,
        output res_index,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_cos,
        input  res_index,
        output res_ready
    );
endinterface

// File: rtl/angle_sweep_ctrl.sv
// Steps a CORDIC angle through NSTEPS points, waits SETTLE cycles per point,
// captures the cosine and hands it downstream over a valid/ready handshake.
module angle_sweep_ctrl #(
    parameter logic [31:0] STEP   = 32'h0595C612,
    parameter int unsigned NSTEPS = 18,
    parameter int unsigned SETTLE = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [31:0]            angle_out,
    input  logic [31:0]            cos_in,
    angle_sweep_ctrl_if.master     res,
    output logic                   busy,
    output logic                   done
);
    localparam logic [7:0] LAST       = 8'(NSTEPS - 1);
    localparam logic [7:0] SETTLE_INI = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [7:0]  cnt;
    logic [31:0] angle;
    logic [31:0] resCos;
    logic [7:0]  resIndex;
    logic        resValid;
    logic        handshake;
    logic        isLast;

    assign handshake     = resValid & res.res_ready;
    assign isLast        = (resIndex == LAST);
    assign angle_out     = angle;
    assign res.res_valid = resValid;
    assign res.res_cos   = resCos;
    assign res.res_index = resIndex;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // abort outranks both start and the handshake
    always_comb begin
        stateNext = state;
        unique case (state)
            S_IDLE: begin
                if (start && !abort) stateNext = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)          stateNext = S_IDLE;
                else if (cnt == '0) stateNext = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (abort)          stateNext = S_IDLE;
                else if (handshake) stateNext = isLast ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                stateNext = S_IDLE;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            angle    <= '0;
            resCos   <= '0;
            resIndex <= '0;
            resValid <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (stateNext != S_IDLE);
            done <= (stateNext == S_DONE);
            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        angle    <= '0;
                        resIndex <= '0;
                        cnt      <= SETTLE_INI;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        resValid <= 1'b0;
                    end else if (cnt == '0) begin
                        resCos   <= cos_in;
                        resValid <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_OUTPUT: begin
                    if (abort) begin
                        resValid <= 1'b0;
                    end else if (handshake) begin
                        resValid <= 1'b0;
                        if (!isLast) begin
                            angle    <= angle + STEP;
                            resIndex <= resIndex + 8'd1;
                            cnt      <= SETTLE_INI;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_angle_sweep_ctrl.sv
// Bench for angle_sweep_ctrl: scoreboarded sweeps, stall, abort, reset,
// ignored start while busy, and angle wrap on a second instance.
module tb_angle_sweep_ctrl;
    localparam logic [31:0] STEP_A = 32'h0595C612;
    localparam int          NS_A   = 18;
    localparam logic [31:0] STEP_B = 32'h40000000;
    localparam int          NS_B   = 6;

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] angle;
        logic [31:0] cos;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        startA;
    logic        abortA;
    logic [31:0] angleA;
    logic [31:0] cosA;
    logic        busyA;
    logic        doneA;
    logic        startB;
    logic        abortB;
    logic [31:0] angleB;
    logic [31:0] cosB;
    logic        busyB;
    logic        doneB;

    int   nAsserts = 0;
    int   nFails   = 0;
    exp_t q[$];

    angle_sweep_ctrl_if ifA ();
    angle_sweep_ctrl_if ifB ();

    // stand-in CORDIC: exact cosine in Q2.30
    function automatic logic [31:0] cosRef(input logic [31:0] a);
        real r;
        r = $itor($signed(a)) / 1073741824.0;
        return 32'($rtoi($cos(r) * 1073741824.0));
    endfunction

    assign cosA = cosRef(angleA);
    assign cosB = cosRef(angleB);

    angle_sweep_ctrl dutA (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (startA),
        .abort     (abortA),
        .angle_out (angleA),
        .cos_in    (cosA),
        .res       (ifA),
        .busy      (busyA),
        .done      (doneA)
    );

    angle_sweep_ctrl #(
        .STEP   (STEP_B),
        .NSTEPS (NS_B)
    ) dutB (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (startB),
        .abort     (abortB),
        .angle_out (angleB),
        .cos_in    (cosB),
        .res       (ifB),
        .busy      (busyB),
        .done      (doneB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic waitValidA(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            startA = 1'b0;
        end while (!ifA.res_valid && lat < 40);
    endtask

    task automatic waitValidB(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            startB = 1'b0;
        end while (!ifB.res_valid && lat < 40);
    endtask

    task automatic sweepA(input int stallIdx, input int abortIdx,
                          input int busyIdx);
        int   lat;
        exp_t e;
        logic [31:0] lastAng;
        q.delete();
        for (int i = 0; i < NS_A; i++) begin
            e.idx   = 8'(i);
            e.angle = 32'(i) * STEP_A;
            e.cos   = cosRef(e.angle);
            q.push_back(e);
        end
        @(negedge clk);
        startA = 1'b1;
        for (int i = 0; i < NS_A; i++) begin
            waitValidA(lat);
            check("valid_seen", 32'(ifA.res_valid), 32'd1);
            if (!ifA.res_valid) return;
            e = q.pop_front();
            check("latency", 32'(lat), 32'd5);
            check("index", 32'(ifA.res_index), 32'(e.idx));
            check("cos", ifA.res_cos, e.cos);
            check("angle", angleA, e.angle);
            check("busy", 32'(busyA), 32'd1);
            if (i == busyIdx) startA = 1'b1;
            if (i == stallIdx) begin
                ifA.res_ready = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    startA = 1'b0;
                    check("stall_valid", 32'(ifA.res_valid), 32'd1);
                    check("stall_index", 32'(ifA.res_index), 32'(e.idx));
                    check("stall_cos", ifA.res_cos, e.cos);
                    check("stall_angle", angleA, e.angle);
                end
                ifA.res_ready = 1'b1;
            end
            if (i == abortIdx) begin
                abortA = 1'b1;
                @(negedge clk);
                abortA = 1'b0;
                check("abort_valid", 32'(ifA.res_valid), 32'd0);
                check("abort_busy", 32'(busyA), 32'd0);
                check("abort_done", 32'(doneA), 32'd0);
                check("abort_index", 32'(ifA.res_index), 32'(e.idx));
                @(negedge clk);
                check("abort_done2", 32'(doneA), 32'd0);
                check("abort_busy2", 32'(busyA), 32'd0);
                q.delete();
                return;
            end
        end
        lastAng = 32'(NS_A - 1) * STEP_A;
        @(negedge clk);
        check("done_pulse", 32'(doneA), 32'd1);
        check("done_valid", 32'(ifA.res_valid), 32'd0);
        @(negedge clk);
        check("done_clear", 32'(doneA), 32'd0);
        check("idle_busy", 32'(busyA), 32'd0);
        check("last_angle", angleA, lastAng);
        check("last_cos", ifA.res_cos, cosRef(lastAng));
        check("sb_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] angB [NS_B];
        angB = '{32'h0, 32'h40000000, 32'h80000000,
                 32'hC0000000, 32'h0, 32'h40000000};
        reset_n       = 1'b0;
        startA        = 1'b0;
        abortA        = 1'b0;
        startB        = 1'b0;
        abortB        = 1'b0;
        ifA.res_ready = 1'b1;
        ifB.res_ready = 1'b1;
        #1;
        check("rst_valid", 32'(ifA.res_valid), 32'd0);
        check("rst_index", 32'(ifA.res_index), 32'd0);
        check("rst_cos", ifA.res_cos, 32'd0);
        check("rst_angle", angleA, 32'd0);
        check("rst_busy", 32'(busyA), 32'd0);
        check("rst_done", 32'(doneA), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // abort beats start in IDLE
        @(negedge clk);
        startA = 1'b1;
        abortA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        abortA = 1'b0;
        check("abort_start_busy", 32'(busyA), 32'd0);
        @(negedge clk);
        check("abort_start_busy2", 32'(busyA), 32'd0);
        check("abort_start_valid", 32'(ifA.res_valid), 32'd0);

        sweepA(-1, -1, -1);
        sweepA(3, -1, 2);
        sweepA(-1, 5, -1);
        sweepA(-1, -1, -1);

        // asynchronous reset in the middle of SETTLE for point 1
        @(negedge clk);
        startA = 1'b1;
        waitValidA(lat);
        check("rs_valid", 32'(ifA.res_valid), 32'd1);
        @(negedge clk);
        check("rs_angle_pre", angleA, STEP_A);
        check("rs_busy_pre", 32'(busyA), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rs_valid", 32'(ifA.res_valid), 32'd0);
        check("rs_index", 32'(ifA.res_index), 32'd0);
        check("rs_cos", ifA.res_cos, 32'd0);
        check("rs_angle", angleA, 32'd0);
        check("rs_busy", 32'(busyA), 32'd0);
        check("rs_done", 32'(doneA), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rs_idle_busy", 32'(busyA), 32'd0);
        check("rs_idle_valid", 32'(ifA.res_valid), 32'd0);

        // wrap-around sweep on the second instance
        @(negedge clk);
        startB = 1'b1;
        for (int i = 0; i < NS_B; i++) begin
            waitValidB(lat);
            check("b_valid", 32'(ifB.res_valid), 32'd1);
            check("b_latency", 32'(lat), 32'd5);
            check("b_index", 32'(ifB.res_index), 32'(i));
            check("b_angle", angleB, angB[i]);
            check("b_cos", ifB.res_cos, cosRef(angB[i]));
        end
        @(negedge clk);
        check("b_done", 32'(doneB), 32'd1);
        @(negedge clk);
        check("b_done_clear", 32'(doneB), 32'd0);
        check("b_busy", 32'(busyB), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFails);
        $finish;
    end
endmodule
